// File: rtl/cix32_descriptor_loader.sv
`default_nettype none
// ============================================================================
//  Module   : cix32_descriptor_loader
//  Purpose  : Segment-load sequencer that validates a selector, fetches or
//             synthesizes its descriptor and commits it to the segment file.
//  Revision : 1.0  initial release
// ============================================================================

package cix32_pkg;
    typedef enum logic [1:0] {
        MODE_REAL      = 2'b00,
        MODE_PROTECTED = 2'b01
    } cpu_mode_t;
endpackage

module cix32_descriptor_loader (
    input  logic                 clk,
    input  logic                 rst,
    input  cix32_pkg::cpu_mode_t cpu_mode,
    input  logic                 load_req,
    input  logic [2:0]           load_seg,
    input  logic [15:0]          load_sel,
    output logic                 load_busy,
    output logic                 load_done,
    output logic                 load_fault,
    output logic [1:0]           fault_code,
    input  logic [31:0]          gdt_base,
    input  logic [15:0]          gdt_limit,
    output logic                 mem_req,
    output logic [31:0]          mem_addr,
    input  logic                 mem_ack,
    input  logic [31:0]          mem_rdata,
    output logic                 seg_we,
    output logic [2:0]           seg_addr,
    output logic [15:0]          seg_wdata,
    output logic                 cache_we,
    output logic [31:0]          cache_base,
    output logic [31:0]          cache_limit,
    output logic [7:0]           cache_attrs
);
    import cix32_pkg::*;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_RD_LO  = 3'd2,
        ST_RD_HI  = 3'd3,
        ST_COMMIT = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    localparam logic [1:0] FC_GP   = 2'b01;
    localparam logic [1:0] FC_NP   = 2'b10;
    localparam logic [1:0] FC_NULL = 2'b11;
    localparam logic [2:0] SEG_CS  = 3'd1;
    localparam logic [2:0] SEG_SS  = 3'd2;

    state_t      state_q, state_d;
    logic [2:0]  seg_q, seg_d;
    logic [15:0] sel_q, sel_d;
    cpu_mode_t   mode_q, mode_d;
    logic [31:0] lo_q, lo_d;

    logic        load_busy_q, load_busy_d, load_done_q, load_done_d;
    logic        load_fault_q, load_fault_d, mem_req_q, mem_req_d;
    logic [1:0]  fault_code_q, fault_code_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        seg_we_q, seg_we_d, cache_we_q, cache_we_d;
    logic [2:0]  seg_addr_q, seg_addr_d;
    logic [15:0] seg_wdata_q, seg_wdata_d;
    logic [31:0] cache_base_q, cache_base_d, cache_limit_q, cache_limit_d;
    logic [7:0]  cache_attrs_q, cache_attrs_d;

    // Descriptor decode from the high word on the bus and the captured low word
    logic [7:0]  w_attrs;
    logic [31:0] w_base;
    logic [19:0] w_limit20;
    logic [31:0] w_limit;
    assign w_attrs   = mem_rdata[15:8];
    assign w_base    = {mem_rdata[31:24], mem_rdata[7:0], lo_q[31:16]};
    assign w_limit20 = {mem_rdata[19:16], lo_q[15:0]};
    assign w_limit   = mem_rdata[23] ? {w_limit20, 12'hFFF} : {12'h0, w_limit20};

    logic        w_commit, w_fault;
    logic [1:0]  w_code;
    logic [31:0] w_cbase, w_climit;
    logic [7:0]  w_cattrs;

    always_comb begin
        state_d       = state_q;
        seg_d         = seg_q;
        sel_d         = sel_q;
        mode_d        = mode_q;
        lo_d          = lo_q;
        mem_addr_d    = 32'h0;
        w_commit      = 1'b0;
        w_fault       = 1'b0;
        w_code        = 2'b00;
        w_cbase       = 32'h0;
        w_climit      = 32'h0;
        w_cattrs      = 8'h0;

        case (state_q)
            ST_IDLE: begin
                if (load_req) begin
                    seg_d   = load_seg;
                    sel_d   = load_sel;
                    mode_d  = cpu_mode;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (seg_q[2:1] == 2'b11) begin
                    w_fault = 1'b1;
                    w_code  = FC_GP;
                end else if (mode_q == MODE_REAL) begin
                    w_commit = 1'b1;
                    w_cbase  = {12'h0, sel_q, 4'h0};
                    w_climit = 32'h0000FFFF;
                    w_cattrs = 8'h93;
                end else if (mode_q != MODE_PROTECTED) begin
                    w_fault = 1'b1;
                    w_code  = FC_GP;
                end else if (sel_q[15:2] == 14'h0) begin
                    // Null selector: legal for data segments, fatal for CS/SS
                    if (seg_q == SEG_CS || seg_q == SEG_SS) begin
                        w_fault = 1'b1;
                        w_code  = FC_NULL;
                    end else begin
                        w_commit = 1'b1;
                    end
                end else if (sel_q[2]) begin
                    w_fault = 1'b1;
                    w_code  = FC_GP;
                end else if ({sel_q[15:3], 3'b111} > gdt_limit) begin
                    w_fault = 1'b1;
                    w_code  = FC_GP;
                end else begin
                    state_d    = ST_RD_LO;
                    mem_addr_d = gdt_base + {16'h0, sel_q[15:3], 3'b000};
                end
            end
            ST_RD_LO: begin
                mem_addr_d = mem_addr_q;
                if (mem_ack) begin
                    lo_d       = mem_rdata;
                    mem_addr_d = mem_addr_q + 32'd4;
                    state_d    = ST_RD_HI;
                end
            end
            ST_RD_HI: begin
                mem_addr_d = mem_addr_q;
                if (mem_ack) begin
                    mem_addr_d = 32'h0;
                    if (!w_attrs[7]) begin
                        w_fault = 1'b1;
                        w_code  = FC_NP;
                    end else if (!w_attrs[4]) begin
                        w_fault = 1'b1;
                        w_code  = FC_GP;
                    end else begin
                        w_commit = 1'b1;
                        w_cbase  = w_base;
                        w_climit = w_limit;
                        w_cattrs = w_attrs;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (w_commit) state_d = ST_COMMIT;
        if (w_fault)  state_d = ST_FAULT;

        load_done_d   = w_commit;
        seg_we_d      = w_commit;
        cache_we_d    = w_commit;
        seg_addr_d    = w_commit ? seg_q : 3'd0;
        seg_wdata_d   = w_commit ? sel_q : 16'h0;
        cache_base_d  = w_cbase;
        cache_limit_d = w_climit;
        cache_attrs_d = w_cattrs;
        load_fault_d  = w_fault;
        fault_code_d  = w_code;
        load_busy_d   = (state_d != ST_IDLE);
        mem_req_d     = (state_d == ST_RD_LO) || (state_d == ST_RD_HI);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            seg_q         <= 3'd0;
            sel_q         <= 16'h0;
            mode_q        <= MODE_REAL;
            lo_q          <= 32'h0;
            load_busy_q   <= 1'b0;
            load_done_q   <= 1'b0;
            load_fault_q  <= 1'b0;
            fault_code_q  <= 2'b00;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= 32'h0;
            seg_we_q      <= 1'b0;
            seg_addr_q    <= 3'd0;
            seg_wdata_q   <= 16'h0;
            cache_we_q    <= 1'b0;
            cache_base_q  <= 32'h0;
            cache_limit_q <= 32'h0;
            cache_attrs_q <= 8'h0;
        end else begin
            state_q       <= state_d;
            seg_q         <= seg_d;
            sel_q         <= sel_d;
            mode_q        <= mode_d;
            lo_q          <= lo_d;
            load_busy_q   <= load_busy_d;
            load_done_q   <= load_done_d;
            load_fault_q  <= load_fault_d;
            fault_code_q  <= fault_code_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            seg_we_q      <= seg_we_d;
            seg_addr_q    <= seg_addr_d;
            seg_wdata_q   <= seg_wdata_d;
            cache_we_q    <= cache_we_d;
            cache_base_q  <= cache_base_d;
            cache_limit_q <= cache_limit_d;
            cache_attrs_q <= cache_attrs_d;
        end
    end

    assign load_busy   = load_busy_q;
    assign load_done   = load_done_q;
    assign load_fault  = load_fault_q;
    assign fault_code  = fault_code_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign seg_we      = seg_we_q;
    assign seg_addr    = seg_addr_q;
    assign seg_wdata   = seg_wdata_q;
    assign cache_we    = cache_we_q;
    assign cache_base  = cache_base_q;
    assign cache_limit = cache_limit_q;
    assign cache_attrs = cache_attrs_q;

endmodule

`default_nettype wire

// File: tb/tb_cix32_descriptor_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cix32_descriptor_loader
//  Purpose  : Directed self-checking bench for the descriptor loader.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cix32_descriptor_loader;
    import cix32_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    cpu_mode_t   cpu_mode = MODE_REAL;
    logic        load_req = 1'b0;
    logic [2:0]  load_seg = 3'd0;
    logic [15:0] load_sel = 16'h0;
    logic [31:0] gdt_base = 32'h0;
    logic [15:0] gdt_limit = 16'h0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        load_busy, load_done, load_fault, mem_req;
    logic [1:0]  fault_code;
    logic [31:0] mem_addr;
    logic        seg_we, cache_we;
    logic [2:0]  seg_addr;
    logic [15:0] seg_wdata;
    logic [31:0] cache_base, cache_limit;
    logic [7:0]  cache_attrs;

    int checks = 0;
    int errors = 0;

    cix32_descriptor_loader dut (
        .clk(clk), .rst(rst), .cpu_mode(cpu_mode),
        .load_req(load_req), .load_seg(load_seg), .load_sel(load_sel),
        .load_busy(load_busy), .load_done(load_done), .load_fault(load_fault),
        .fault_code(fault_code), .gdt_base(gdt_base), .gdt_limit(gdt_limit),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .seg_we(seg_we), .seg_addr(seg_addr),
        .seg_wdata(seg_wdata), .cache_we(cache_we), .cache_base(cache_base),
        .cache_limit(cache_limit), .cache_attrs(cache_attrs)
    );

    always #5 clk = ~clk;

    // Memory responder: answers after mem_waits idle cycles from a two-word table
    int          mem_waits = 0;
    int          wcnt = 0;
    logic [31:0] lo_addr = 32'h0, desc_lo = 32'h0, desc_hi = 32'h0;
    int          ack_n = 0;
    logic [31:0] ack_addr0 = 32'h0, ack_addr1 = 32'h0;
    int          unstable = 0;
    bit          req_seen = 1'b0;
    logic        prev_req = 1'b0, prev_ack = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    int          done_cnt = 0, fault_cnt = 0;

    always @(negedge clk) begin
        if (mem_req) begin
            req_seen = 1'b1;
            if (prev_req && !prev_ack && mem_addr !== prev_addr) unstable++;
            if (wcnt >= mem_waits) begin
                mem_ack   = 1'b1;
                mem_rdata = (mem_addr == lo_addr) ? desc_lo :
                            (mem_addr == lo_addr + 32'd4) ? desc_hi : 32'hDEADBEEF;
                if (ack_n == 0) ack_addr0 = mem_addr;
                else if (ack_n == 1) ack_addr1 = mem_addr;
                ack_n++;
                wcnt = 0;
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end
        prev_req  = mem_req;
        prev_addr = mem_addr;
        prev_ack  = mem_ack;
        if (load_done)  done_cnt++;
        if (load_fault) fault_cnt++;
    end

    // Captured at the cycle the load finishes
    logic        busy1, start_busy, cap_done, cap_fault, cap_we, cap_cwe;
    logic [1:0]  cap_code;
    logic [2:0]  cap_addr;
    logic [15:0] cap_wdata;
    logic [31:0] cap_base, cap_limit;
    logic [7:0]  cap_attrs;

    task automatic do_load(input cpu_mode_t m, input logic [2:0] s,
                           input logic [15:0] sel, output int cyc);
        @(negedge clk);
        start_busy = load_busy;
        cpu_mode = m; load_seg = s; load_sel = sel; load_req = 1'b1;
        ack_n = 0; req_seen = 1'b0;
        cyc = -1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == 1) begin
                load_req = 1'b0;
                busy1 = load_busy;
            end
            if (load_done || load_fault) begin
                cyc = n;
                cap_done = load_done; cap_fault = load_fault; cap_code = fault_code;
                cap_we = seg_we; cap_cwe = cache_we; cap_addr = seg_addr;
                cap_wdata = seg_wdata; cap_base = cache_base;
                cap_limit = cache_limit; cap_attrs = cache_attrs;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({load_busy, load_done, load_fault, fault_code, mem_req, mem_addr, seg_we,
             seg_addr, seg_wdata, cache_we, cache_base, cache_limit, cache_attrs} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b flt=%b req=%b addr=%h we=%b base=%h want all zero",
                     load_busy, load_done, load_fault, mem_req, mem_addr, seg_we, cache_base);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({load_busy, mem_req, seg_we, load_fault} !== 4'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b req=%b we=%b flt=%b want 0",
                     load_busy, mem_req, seg_we, load_fault);
        end
    endtask

    task automatic test_real_mode;
        int cyc;
        do_load(MODE_REAL, 3'd3, 16'h1234, cyc);
        checks++;
        if (cyc !== 2 || busy1 !== 1'b1 || cap_done !== 1'b1) begin
            errors++;
            $display("FAIL real_timing got cyc=%0d busy1=%b done=%b want cyc=2 busy1=1 done=1", cyc, busy1, cap_done);
        end
        checks++;
        if ({cap_we, cap_cwe, cap_addr, cap_wdata} !== {1'b1, 1'b1, 3'd3, 16'h1234}) begin
            errors++;
            $display("FAIL real_seg got we=%b cwe=%b addr=%0d wdata=%h want 1 1 3 1234", cap_we, cap_cwe, cap_addr, cap_wdata);
        end
        checks++;
        if ({cap_base, cap_limit, cap_attrs} !== {32'h00012340, 32'h0000FFFF, 8'h93} || req_seen) begin
            errors++;
            $display("FAIL real_cache got base=%h limit=%h attrs=%h req=%b want 00012340 0000ffff 93 0",
                     cap_base, cap_limit, cap_attrs, req_seen);
        end
    endtask

    task automatic test_protected(input int waits, input int exp_cyc);
        int cyc;
        gdt_base = 32'h1000; gdt_limit = 16'h00FF; mem_waits = waits;
        lo_addr = 32'h1010; desc_lo = 32'h0000FFFF; desc_hi = 32'h00CF9300;
        unstable = 0;
        do_load(MODE_PROTECTED, 3'd1, 16'h0010, cyc);
        checks++;
        if (cyc !== exp_cyc || cap_done !== 1'b1) begin
            errors++;
            $display("FAIL prot_timing_w%0d got cyc=%0d done=%b want cyc=%0d done=1", waits, cyc, cap_done, exp_cyc);
        end
        checks++;
        if (ack_addr0 !== 32'h1010 || ack_addr1 !== 32'h1014 || unstable !== 0) begin
            errors++;
            $display("FAIL prot_addr_w%0d got %h %h unstable=%0d want 00001010 00001014 0", waits, ack_addr0, ack_addr1, unstable);
        end
        checks++;
        if ({cap_addr, cap_wdata, cap_base, cap_limit, cap_attrs} !== {3'd1, 16'h0010, 32'h0, 32'hFFFFFFFF, 8'h93}) begin
            errors++;
            $display("FAIL prot_cache_w%0d got seg=%0d sel=%h base=%h limit=%h attrs=%h want 1 0010 0 ffffffff 93",
                     waits, cap_addr, cap_wdata, cap_base, cap_limit, cap_attrs);
        end
    endtask

    task automatic test_decode_boundary;
        int cyc;
        gdt_base = 32'h1000; gdt_limit = 16'h00FF; mem_waits = 0;
        lo_addr = 32'h10F8; desc_lo = 32'h12345678; desc_hi = 32'hAB4F93CD;
        do_load(MODE_PROTECTED, 3'd3, 16'h00F8, cyc);
        checks++;
        if (cyc !== 4 || cap_done !== 1'b1 || ack_addr1 !== 32'h10FC) begin
            errors++;
            $display("FAIL limit_edge got cyc=%0d done=%b hiaddr=%h want 4 1 000010fc", cyc, cap_done, ack_addr1);
        end
        checks++;
        if ({cap_base, cap_limit, cap_attrs} !== {32'hABCD1234, 32'h000F5678, 8'h93}) begin
            errors++;
            $display("FAIL byte_gran got base=%h limit=%h attrs=%h want abcd1234 000f5678 93", cap_base, cap_limit, cap_attrs);
        end
        gdt_base = 32'hFFFFFFF8; gdt_limit = 16'h00FF;
        lo_addr = 32'h0; desc_lo = 32'h0000FFFF; desc_hi = 32'h00CF9300;
        do_load(MODE_PROTECTED, 3'd0, 16'h000B, cyc);
        checks++;
        if (cyc !== 4 || ack_addr0 !== 32'h0 || ack_addr1 !== 32'h4 || cap_wdata !== 16'h000B) begin
            errors++;
            $display("FAIL addr_wrap got cyc=%0d a0=%h a1=%h sel=%h want 4 0 4 000b", cyc, ack_addr0, ack_addr1, cap_wdata);
        end
    endtask

    task automatic test_faults;
        int cyc;
        gdt_base = 32'h1000; gdt_limit = 16'h00FF; mem_waits = 0;
        do_load(MODE_PROTECTED, 3'd3, 16'h0100, cyc);
        checks++;
        if (cyc !== 2 || cap_fault !== 1'b1 || cap_code !== 2'b01 || req_seen || cap_we !== 1'b0) begin
            errors++;
            $display("FAIL gp_limit got cyc=%0d flt=%b code=%b req=%b we=%b want 2 1 01 0 0", cyc, cap_fault, cap_code, req_seen, cap_we);
        end
        do_load(MODE_PROTECTED, 3'd2, 16'h0003, cyc);
        checks++;
        if (cyc !== 2 || cap_fault !== 1'b1 || cap_code !== 2'b11) begin
            errors++;
            $display("FAIL null_ss got cyc=%0d flt=%b code=%b want 2 1 11", cyc, cap_fault, cap_code);
        end
        lo_addr = 32'h1010; desc_lo = 32'h0000FFFF; desc_hi = 32'h00001300;
        do_load(MODE_PROTECTED, 3'd3, 16'h0010, cyc);
        checks++;
        if (cyc !== 4 || cap_fault !== 1'b1 || cap_code !== 2'b10 || cap_we !== 1'b0) begin
            errors++;
            $display("FAIL np got cyc=%0d flt=%b code=%b we=%b want 4 1 10 0", cyc, cap_fault, cap_code, cap_we);
        end
        desc_hi = 32'h00008900;
        do_load(MODE_PROTECTED, 3'd3, 16'h0010, cyc);
        checks++;
        if (cyc !== 4 || cap_fault !== 1'b1 || cap_code !== 2'b01) begin
            errors++;
            $display("FAIL sys_desc got cyc=%0d flt=%b code=%b want 4 1 01", cyc, cap_fault, cap_code);
        end
        do_load(MODE_REAL, 3'd6, 16'h1234, cyc);
        checks++;
        if (cyc !== 2 || cap_fault !== 1'b1 || cap_code !== 2'b01) begin
            errors++;
            $display("FAIL seg6 got cyc=%0d flt=%b code=%b want 2 1 01", cyc, cap_fault, cap_code);
        end
        do_load(MODE_PROTECTED, 3'd3, 16'h0014, cyc);
        checks++;
        if (cyc !== 2 || cap_fault !== 1'b1 || cap_code !== 2'b01 || req_seen) begin
            errors++;
            $display("FAIL ldt got cyc=%0d flt=%b code=%b req=%b want 2 1 01 0", cyc, cap_fault, cap_code, req_seen);
        end
        do_load(cpu_mode_t'(2'b10), 3'd3, 16'h0010, cyc);
        checks++;
        if (cyc !== 2 || cap_fault !== 1'b1 || cap_code !== 2'b01) begin
            errors++;
            $display("FAIL bad_mode got cyc=%0d flt=%b code=%b want 2 1 01", cyc, cap_fault, cap_code);
        end
    endtask

    task automatic test_null_es;
        int cyc;
        do_load(MODE_PROTECTED, 3'd0, 16'h0000, cyc);
        checks++;
        if (cyc !== 2 || cap_done !== 1'b1 || {cap_base, cap_limit, cap_attrs} !== '0 || req_seen) begin
            errors++;
            $display("FAIL null_es got cyc=%0d done=%b base=%h limit=%h attrs=%h want 2 1 0 0 0",
                     cyc, cap_done, cap_base, cap_limit, cap_attrs);
        end
    endtask

    task automatic test_busy_ignore;
        int d0;
        gdt_base = 32'h1000; gdt_limit = 16'h00FF; mem_waits = 0;
        lo_addr = 32'h1010; desc_lo = 32'h0000FFFF; desc_hi = 32'h00CF9300;
        @(negedge clk);
        d0 = done_cnt;
        cpu_mode = MODE_PROTECTED; load_seg = 3'd1; load_sel = 16'h0010; load_req = 1'b1;
        @(negedge clk);
        load_sel = 16'h0020; load_seg = 3'd3;
        repeat (3) @(negedge clk);
        checks++;
        if (load_done !== 1'b1 || seg_wdata !== 16'h0010) begin
            errors++;
            $display("FAIL busy_first got done=%b sel=%h want 1 0010", load_done, seg_wdata);
        end
        load_req = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (done_cnt - d0 !== 1 || load_busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore got dones=%0d busy=%b want 1 0", done_cnt - d0, load_busy);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        do_load(MODE_REAL, 3'd0, 16'h1111, cyc);
        do_load(MODE_REAL, 3'd5, 16'h2222, cyc);
        checks++;
        if (start_busy !== 1'b0 || cyc !== 2 || {cap_addr, cap_base} !== {3'd5, 32'h00022220}) begin
            errors++;
            $display("FAIL b2b_commit got busy0=%b cyc=%0d seg=%0d base=%h want 0 2 5 00022220", start_busy, cyc, cap_addr, cap_base);
        end
        do_load(MODE_REAL, 3'd7, 16'h3333, cyc);
        checks++;
        if (start_busy !== 1'b0 || cyc !== 2 || cap_code !== 2'b01 || cap_we !== 1'b0 || cap_done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_fault got busy0=%b cyc=%0d code=%b we=%b done=%b want 0 2 01 0 0",
                     start_busy, cyc, cap_code, cap_we, cap_done);
        end
    endtask

    task automatic test_reset_mid_fetch;
        int d0, f0, cyc;
        gdt_base = 32'h1000; gdt_limit = 16'h00FF; mem_waits = 3;
        lo_addr = 32'h1010; desc_lo = 32'h0000FFFF; desc_hi = 32'h00CF9300;
        @(negedge clk);
        cpu_mode = MODE_PROTECTED; load_seg = 3'd1; load_sel = 16'h0010; load_req = 1'b1;
        ack_n = 0;
        @(negedge clk);
        load_req = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || ack_n !== 1 || mem_addr !== 32'h1014) begin
            errors++;
            $display("FAIL mid_fetch_pre got req=%b acks=%0d addr=%h want 1 1 00001014", mem_req, ack_n, mem_addr);
        end
        d0 = done_cnt; f0 = fault_cnt;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({load_busy, load_done, load_fault, fault_code, mem_req, mem_addr, seg_we,
             seg_addr, seg_wdata, cache_we, cache_base, cache_limit, cache_attrs} !== '0) begin
            errors++;
            $display("FAIL mid_reset got busy=%b req=%b addr=%h we=%b want all zero", load_busy, mem_req, mem_addr, seg_we);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt !== d0 || fault_cnt !== f0 || load_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet got dones=%0d faults=%0d busy=%b want 0 0 0", done_cnt - d0, fault_cnt - f0, load_busy);
        end
        mem_waits = 0;
        do_load(MODE_PROTECTED, 3'd1, 16'h0010, cyc);
        checks++;
        if (cyc !== 4 || cap_done !== 1'b1 || cap_limit !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL post_reset got cyc=%0d done=%b limit=%h want 4 1 ffffffff", cyc, cap_done, cap_limit);
        end
    endtask

    initial begin
        test_reset;
        test_real_mode;
        test_protected(0, 4);
        test_protected(3, 10);
        test_decode_boundary;
        test_faults;
        test_null_es;
        test_busy_ignore;
        test_back_to_back;
        test_reset_mid_fetch;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
